// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and the special-case operand/result patterns.
package div_pkg;

    // Controller states; the normal path is IDLE->PREP->CALC->FIX->DONE,
    // special cases jump straight from IDLE to DONE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    // Widest operand the helpers below can describe; the divider slices
    // these wide patterns down to its own width.
    localparam int MAX_N = 64;

    // All-ones pattern: the quotient reported for a zero divisor, and also
    // the two's-complement encoding of -1.
    localparam logic [MAX_N-1:0] ALL_ONES_WIDE = '1;

    // Most-negative two's-complement value for a given width (only the MSB set).
    function automatic logic [MAX_N-1:0] most_neg_pattern(input int width);
        logic [MAX_N-1:0] pattern;
        pattern = '0;
        pattern[width-1] = 1'b1;
        return pattern;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the partial remainder left bringing in
// the next dividend bit, trial-subtract the divisor on an N+1-bit datapath,
// and keep the difference only if it did not go negative.
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_in,
    input  logic         msb_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // Shift-subtract-restore; the incoming remainder is always below the
    // divisor, so the restored or reduced result always fits in N bits.
    always_comb begin
        shifted = {rem_in, msb_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[N];
        rem_out = q_bit ? diff[N-1:0] : shifted[N-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider with valid/ready handshakes on both sides.
// Normal operands take one PREP cycle, N restoring CALC cycles and one FIX
// cycle; a zero divisor and the most-negative/-1 overflow case finish at once.
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    import div_pkg::*;

    localparam int               CNT_W         = $clog2(N) + 1;
    localparam logic [MAX_N-1:0] MOST_NEG_WIDE = most_neg_pattern(N);
    localparam logic [N-1:0]     MOST_NEG      = MOST_NEG_WIDE[N-1:0];
    localparam logic [N-1:0]     ALL_ONES      = ALL_ONES_WIDE[N-1:0];
    localparam logic [CNT_W-1:0] LAST_ITER     = CNT_W'(N - 1);

    div_state_t       state;
    div_state_t       next_state;

    logic [N-1:0]     dividend_r;
    logic [N-1:0]     divisor_r;
    logic [N-1:0]     abs_divisor;
    logic [N-1:0]     quo_shift;
    logic [N-1:0]     part_rem;
    logic             q_neg;
    logic             r_neg;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             divisor_is_zero;
    logic             is_overflow_case;
    logic [N-1:0]     step_rem;
    logic             step_bit;

    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the step and the new quotient bit enters at the LSB.
    div_step #(
        .N(N)
    ) u_step (
        .rem_in  (part_rem),
        .msb_in  (quo_shift[N-1]),
        .divisor (abs_divisor),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // Special-case detection looks at the live operands since it decides
    // the very first transition out of IDLE.
    always_comb begin
        accept           = (state == IDLE) && in_valid;
        divisor_is_zero  = (divisor == '0);
        is_overflow_case = (dividend == MOST_NEG) && (divisor == ALL_ONES);
    end

    // State register; reset abandons any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; DONE only returns to IDLE, so a new
    // request cannot be accepted in the same cycle a result is consumed.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (divisor_is_zero || is_overflow_case) begin
                        next_state = DONE;
                    end else begin
                        next_state = PREP;
                    end
                end
            end
            PREP: begin
                next_state = CALC;
            end
            CALC: begin
                if (count == LAST_ITER) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture operands, convert to magnitudes, iterate, then
    // restore signs; results are only written on the way into DONE so they
    // stay put while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_r  <= '0;
            divisor_r   <= '0;
            abs_divisor <= '0;
            quo_shift   <= '0;
            part_rem    <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dividend_r <= dividend;
                        divisor_r  <= divisor;
                        if (divisor_is_zero) begin
                            quotient    <= ALL_ONES;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else if (is_overflow_case) begin
                            quotient    <= dividend;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    end
                end
                PREP: begin
                    quo_shift   <= dividend_r[N-1] ? -dividend_r : dividend_r;
                    abs_divisor <= divisor_r[N-1] ? -divisor_r : divisor_r;
                    part_rem    <= '0;
                    q_neg       <= dividend_r[N-1] ^ divisor_r[N-1];
                    r_neg       <= dividend_r[N-1];
                    count       <= '0;
                end
                CALC: begin
                    part_rem  <= step_rem;
                    quo_shift <= {quo_shift[N-2:0], step_bit};
                    count     <= count + 1'b1;
                end
                FIX: begin
                    quotient  <= q_neg ? -quo_shift : quo_shift;
                    remainder <= r_neg ? -part_rem : part_rem;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits (even, >= 4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port dividend  input  N  signed two's-complement dividend.
REQ-007 SHALL have port divisor  input  N  signed two's-complement divisor.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port quotient  output  N  signed quotient.
REQ-011 SHALL have port remainder  output  N  signed remainder.
REQ-012 SHALL have port div_by_zero  output  1  divisor was zero, valid with out_valid.
REQ-013 SHALL have port overflow  output  1  most-negative / -1 case, valid with out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, PREP, CALC, FIX, DONE.
REQ-015 SHALL assert in_ready only in IDLE; a request is accepted on an edge where in_valid && in_ready, and operands are registered at that edge.
REQ-016 SHALL on acceptance with divisor == 0 go IDLE->DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-017 SHALL on acceptance with dividend = 2^(N-1) pattern and divisor = -1 go IDLE->DONE with quotient = dividend, remainder = 0, overflow = 1.
REQ-018 SHALL otherwise go IDLE->PREP; PREP registers absolute values and result signs (q sign = sign XOR, r sign = dividend sign), then -> CALC.
REQ-019 SHALL in CALC perform one restoring step per cycle for exactly N cycles: shift partial remainder left by one bringing in next dividend MSB, subtract |divisor| on an N+1-bit datapath, keep the difference and set quotient bit if non-negative, else restore and clear the bit.
REQ-020 SHALL use an iteration counter of ceil(log2(N))+1 bits, cleared in PREP; CALC -> FIX when the counter reaches N-1.
REQ-021 SHALL in FIX negate quotient/remainder per registered signs (truncation toward zero, remainder takes dividend sign), then -> DONE.
REQ-022 SHALL for the normal path raise out_valid exactly N+3 rising edges after the accepting edge; special cases (REQ-016/017) raise out_valid on the edge after acceptance.
REQ-023 SHALL assert out_valid only in DONE and hold quotient, remainder, div_by_zero, overflow stable while out_valid && !out_ready.
REQ-024 SHALL leave DONE -> IDLE on an edge with out_ready high; in_ready rises in that following cycle (no same-cycle accept-through).
REQ-025 SHALL clear div_by_zero and overflow on every accepted normal-path request.
REQ-026 SHALL ignore in_valid and operand changes outside IDLE.

Reset
REQ-027 SHALL on rst high immediately force state IDLE, in_ready = 1 (once rst low), out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, overflow = 0, counter = 0.
REQ-028 SHALL abandon any in-flight division on reset mid-operation, producing no out_valid for it.

Structure
REQ-029 SHALL place the FSM state encoding and the special-case constants (MOST_NEG pattern, all-ones quotient) in shared package div_pkg.
REQ-030 SHALL instantiate one combinational sub-module div_step (N+1-bit shift-subtract-restore step returning next partial remainder and quotient bit).

Verification
REQ-031 N=32: dividend 100, divisor 7 -> quotient 14, remainder 2, flags 0, out_valid 35 edges after accept.
REQ-032 N=32: dividend -100, divisor 7 -> quotient -14, remainder -2; dividend 100, divisor -7 -> quotient -14, remainder 2.
REQ-033 N=32: dividend 7, divisor 0 -> quotient 0xFFFFFFFF, remainder 7, div_by_zero 1, out_valid one edge after accept.
REQ-034 N=32: dividend 0x80000000, divisor 0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow 1.
REQ-035 Backpressure: out_ready low 5 cycles after out_valid -> outputs stable, in_ready low; out_ready high -> IDLE next edge.
REQ-036 Reset asserted at CALC iteration 10 -> out_valid stays 0, in_ready 1 after release; next request 1000/10 -> quotient 100, remainder 0.
